mem_port_arbiter: RTL and testbench

- Sequencer and arbiter for the processor's single byte-wide memory.
- Shares the memory between two word requesters: instruction fetch (IF) and load/store (LS).
- Each accepted word request is serialised into four byte beats on the memory port. The assembled read word, or a write acknowledge, is returned to the requester that issued it.
- Sits between the fetch/LSU logic of the core and the memory array; it replaces direct multi-byte indexing of the array.

---
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide synchronous memory between IF and LS word requesters,
// serialising each word into four little-endian beats and returning the result to its owner.
module mem_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [31:0]       if_addr,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic              ls_req_we,
    input  logic [31:0]       ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_rsp_valid,
    output logic [31:0]       ls_rsp_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    typedef enum logic [1:0] {IDLE, BEAT, DRAIN, RESP} state_t;
    state_t r_state, w_next;
    logic [1:0] r_cnt, r_rd_k;
    logic r_owner, r_last, r_we, r_rd_v;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0] r_wdata, r_asm, r_if_data, r_ls_data;
    logic w_idle, w_if_win, w_ls_win, w_accept, w_unused;
    logic [31:0] w_word;

    // r_owner and r_last use 1 = LS, 0 = IF
    assign w_idle       = (r_state == IDLE) && !rst;
    assign w_if_win     = if_req_valid && (!ls_req_valid || (RR_ENABLE && r_last));
    assign w_ls_win     = ls_req_valid && !w_if_win;
    assign if_req_ready = w_idle && w_if_win;
    assign ls_req_ready = w_idle && w_ls_win;
    assign w_accept     = if_req_ready || ls_req_ready;
    assign w_word       = {mem_rdata, r_asm[23:0]};
    assign w_unused     = ^{if_addr, ls_addr};

    assign mem_en       = r_state == BEAT;
    assign mem_we       = mem_en && r_we;
    assign mem_addr     = mem_en ? r_addr + ADDR_W'(r_cnt) : '0;
    assign mem_wdata    = mem_we ? r_wdata[{r_cnt, 3'b000} +: 8] : 8'h00;
    assign if_rsp_valid = (r_state == RESP) && !r_owner;
    assign ls_rsp_valid = (r_state == RESP) && r_owner;
    assign if_rsp_data  = r_if_data;
    assign ls_rsp_data  = r_ls_data;

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? BEAT : IDLE;
            BEAT:    w_next = (r_cnt != 2'd3) ? BEAT : (r_we ? RESP : DRAIN);
            DRAIN:   w_next = RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_cnt     <= '0;
            r_rd_k    <= '0;
            r_rd_v    <= 1'b0;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_asm     <= '0;
            r_if_data <= '0;
            r_ls_data <= '0;
        end else begin
            // read data lags its beat by one cycle, so track which lane it belongs to
            r_rd_v <= (r_state == BEAT) && !r_we;
            r_rd_k <= r_cnt;
            if (r_rd_v) r_asm[{r_rd_k, 3'b000} +: 8] <= mem_rdata;
            if (w_accept) begin
                r_owner <= w_ls_win;
                r_last  <= w_ls_win;
                r_we    <= w_ls_win && ls_req_we;
                r_addr  <= w_ls_win ? ls_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
                r_wdata <= ls_wdata;
                r_cnt   <= '0;
            end
            if (r_state == BEAT) r_cnt <= r_cnt + 2'd1;
            if (r_state == BEAT && r_cnt == 2'd3 && r_we) r_ls_data <= '0;
            if (r_state == DRAIN && r_owner) r_ls_data <= w_word;
            if (r_state == DRAIN && !r_owner) r_if_data <= w_word;
        end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors, randomized transactions against a byte-array model,
// plus hand sequences for arbitration and mid-transfer reset.
module tb_mem_port_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic if_req_valid = 1'b0, ls_req_valid = 1'b0, ls_req_we = 1'b0;
    logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
    logic if_req_ready, if_rsp_valid, ls_req_ready, ls_rsp_valid, mem_en, mem_we;
    logic [31:0] if_rsp_data, ls_rsp_data;
    logic [15:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic if_req_ready_0, if_rsp_valid_0, ls_req_ready_0, ls_rsp_valid_0, mem_en_0, mem_we_0;
    logic [31:0] if_rsp_data_0, ls_rsp_data_0;
    logic [15:0] mem_addr_0;
    logic [7:0] mem_wdata_0, mem_rdata_0;
    logic [7:0] mem1 [0:65535];
    logic [7:0] mem0 [0:65535];
    logic [7:0] rmem [0:65535];
    logic [31:0] hold_if = '0, hold_ls = '0;
    int vecs = 0, errs = 0;

    typedef struct {
        bit          ls;
        bit          we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [8];

    mem_port_arbiter #(.ADDR_W(16), .RR_ENABLE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_we(ls_req_we),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(16), .RR_ENABLE(1'b0)) dut_fixed (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready_0), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid_0), .if_rsp_data(if_rsp_data_0),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready_0), .ls_req_we(ls_req_we),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rsp_valid(ls_rsp_valid_0), .ls_rsp_data(ls_rsp_data_0),
        .mem_en(mem_en_0), .mem_we(mem_we_0), .mem_addr(mem_addr_0), .mem_wdata(mem_wdata_0), .mem_rdata(mem_rdata_0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && mem_we) mem1[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem1[mem_addr];
        if (mem_en_0 && mem_we_0) mem0[mem_addr_0] <= mem_wdata_0;
        if (mem_en_0 && !mem_we_0) mem_rdata_0 <= mem0[mem_addr_0];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] b);
        rmem[a] = b;
        mem1[a] <= b;
        mem0[a] <= b;
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a);
        logic [15:0] b0, b1, b2, b3;
        b0 = a[15:0];
        b1 = b0 + 16'd1;
        b2 = b0 + 16'd2;
        b3 = b0 + 16'd3;
        return {rmem[b3], rmem[b2], rmem[b1], rmem[b0]};
    endfunction

    task automatic chk_zero(input string nm);
        chk({nm, " mem"}, 32'({mem_en, mem_we, mem_addr, mem_wdata}), 0);
        chk({nm, " hs"}, 32'({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid}), 0);
        chk({nm, " if_data"}, if_rsp_data, 0);
        chk({nm, " ls_data"}, ls_rsp_data, 0);
    endtask

    // Starts and ends on a falling edge; the DUT is idle on return.
    task automatic txn(input bit ls, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp, input string nm);
        int n = 0;
        logic [15:0] ba;
        if_req_valid = !ls;
        ls_req_valid = ls;
        ls_req_we = we;
        if_addr = a;
        ls_addr = a;
        ls_wdata = wd;
        #1;
        while (!(ls ? ls_req_ready : if_req_ready) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({nm, " accept"}, 32'(n < 20), 1);
        if (n >= 20) begin
            if_req_valid = 1'b0;
            ls_req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            ba = a[15:0] + 16'(k);
            chk($sformatf("%s beat%0d en/we", nm, k), 32'({mem_en, mem_we}), 32'({1'b1, we}));
            chk($sformatf("%s beat%0d addr", nm, k), 32'(mem_addr), 32'(ba));
            if (we) chk($sformatf("%s beat%0d wdata", nm, k), 32'(mem_wdata), 32'(wd[8*k +: 8]));
            chk($sformatf("%s beat%0d rdy/rsp", nm, k),
                32'({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid}), 0);
            @(negedge clk);
        end
        if (!we) begin
            chk({nm, " drain"}, 32'({mem_en, if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid}), 0);
            @(negedge clk);
        end
        chk({nm, " rsp_valid"}, 32'({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid}),
            ls ? 32'h1 : 32'h2);
        chk({nm, " rsp_data"}, ls ? ls_rsp_data : if_rsp_data, exp);
        chk({nm, " other_data"}, ls ? if_rsp_data : ls_rsp_data, ls ? hold_if : hold_ls);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        if (ls) hold_ls = exp;
        else hold_if = exp;
        if (we) for (int k = 0; k < 4; k++) rmem[a[15:0] + 16'(k)] = wd[8*k +: 8];
        @(negedge clk);
        chk({nm, " after"}, 32'({if_rsp_valid, ls_rsp_valid}), 0);
        chk({nm, " hold"}, ls ? ls_rsp_data : if_rsp_data, exp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit g1[$], g0[$];
        int n;
        bit ls, we;
        logic [31:0] a, wd;
        tbl[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0513};
        tbl[1] = '{1'b1, 1'b1, 32'h0000_0050, 32'hDEAD_BEEF, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_0050, 32'h0, 32'hDEAD_BEEF};
        tbl[3] = '{1'b1, 1'b1, 32'h0000_FFFE, 32'hDDCC_BBAA, 32'h0};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_FFFE, 32'h0, 32'hDDCC_BBAA};
        tbl[5] = '{1'b0, 1'b0, 32'h1234_0010, 32'h0, 32'h1234_5678};
        tbl[6] = '{1'b0, 1'b0, 32'h0001_FFFE, 32'h0, 32'hDDCC_BBAA};
        tbl[7] = '{1'b1, 1'b0, 32'hABCD_0051, 32'h0, 32'h00DE_ADBE};
        for (int i = 0; i < 65536; i++) poke(16'(i), 8'h00);
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // both requesters held: RR alternates starting with IF, fixed priority always picks LS
        if_addr = 32'h10;
        ls_addr = 32'h50;
        ls_req_we = 1'b0;
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        n = 0;
        #1;
        while ((g1.size() < 4 || g0.size() < 4) && n < 60) begin
            if ((if_req_ready || ls_req_ready) && g1.size() < 4) g1.push_back(ls_req_ready);
            if ((if_req_ready_0 || ls_req_ready_0) && g0.size() < 4) g0.push_back(ls_req_ready_0);
            if (g1.size() < 4 || g0.size() < 4) begin
                @(negedge clk);
                #1;
            end
            n++;
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        chk("arb_rr count", g1.size(), 4);
        chk("arb_fixed count", g0.size(), 4);
        for (int i = 0; i < g1.size(); i++) chk($sformatf("arb_rr grant%0d", i), 32'(g1[i]), 32'(i % 2));
        for (int i = 0; i < g0.size(); i++) chk($sformatf("arb_fixed grant%0d", i), 32'(g0[i]), 1);
        @(negedge clk);

        poke(16'h0000, 8'h13);
        poke(16'h0001, 8'h05);
        poke(16'h0010, 8'h78);
        poke(16'h0011, 8'h56);
        poke(16'h0012, 8'h34);
        poke(16'h0013, 8'h12);
        @(negedge clk);
        for (int i = 0; i < 8; i++)
            txn(tbl[i].ls, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].exp, $sformatf("tbl%0d", i));

        for (int i = 0; i < 40; i++) begin
            ls = 1'($urandom_range(1));
            we = ls && 1'($urandom_range(1));
            a = $urandom;
            if ($urandom_range(3) == 0) a[15:0] = 16'hFFFC + 16'($urandom_range(3));
            wd = $urandom;
            if ($urandom_range(2) == 0) @(negedge clk);
            txn(ls, we, a, wd, we ? 32'h0 : mread(a), $sformatf("rnd%0d", i));
        end

        // reset in cycle 3 of a store: beats 0 and 1 land, nothing after
        for (int k = 0; k < 4; k++) poke(16'h0100 + 16'(k), 8'h00);
        @(negedge clk);
        ls_addr = 32'h0100;
        ls_wdata = 32'h1122_3344;
        ls_req_we = 1'b1;
        ls_req_valid = 1'b1;
        #1;
        chk("rst_store accept", 32'(ls_req_ready), 1);
        repeat (3) @(negedge clk);
        chk("rst_store beat2 addr", 32'(mem_addr), 32'h0102);
        rst = 1'b1;
        if_req_valid = 1'b1;
        #1;
        chk_zero("rst_mid");
        repeat (2) begin
            @(negedge clk);
            #1;
            chk_zero("rst_hold");
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release grant", 32'({if_req_ready, ls_req_ready}), 32'h2);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        hold_if = '0;
        hold_ls = '0;
        rmem[16'h0100] = 8'h44;
        rmem[16'h0101] = 8'h33;
        @(negedge clk);
        txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, mread(32'h0100), "rst_readback");
        chk("rst_readback model", mread(32'h0100), 32'h0000_3344);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
